alu_arbiter: RTL and testbench

- Shares one ALU instance between two requesters: the main datapath (req0) and an auxiliary unit such as a branch-compare or address helper (req1).
- Arbitrates round-robin, registers the chosen operands onto the ALU inputs, and captures result and zero.
- Returns the captured result to the granted requester over a valid/ready handshake.
- Sits between the requesters and the single ALU; the ALU itself stays purely combinational.

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Round-robin arbitration between req0 (main datapath) and req1 (auxiliary
// unit). The winner's operands are registered onto alu_rs/alu_rt/alu_ctrl,
// the ALU settles for one cycle, and result/zero are captured and returned
// to the granted requester over a valid/ready handshake.
//
// State table
//   state | meaning
//   IDLE  | arbitrating; reqN_ready offered to the selected requester
//   EXEC  | ALU settling on registered operands; capture at end of cycle
//   RESP  | rsp{grant}_valid held until the requester takes the result
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   reqN_valid/ready/rs/rt/ctrl     request side, requester N (N = 0, 1)
//   rspN_valid/ready/result/zero    response side, requester N
//   alu_rs/alu_rt/alu_ctrl          registered operands to the ALU
//   alu_result/alu_zero             combinational ALU outputs
//   busy                            high in EXEC or RESP
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_rs,
    input  logic [WIDTH-1:0]  req0_rt,
    input  logic [CTRL_W-1:0] req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_zero,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_rs,
    input  logic [WIDTH-1:0]  req1_rt,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_zero,
    output logic [WIDTH-1:0]  alu_rs,
    output logic [WIDTH-1:0]  alu_rt,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q,       state_d;
    logic              last_grant_q,  last_grant_d;
    logic              grant_id_q,    grant_id_d;
    logic [WIDTH-1:0]  alu_rs_q,      alu_rs_d;
    logic [WIDTH-1:0]  alu_rt_q,      alu_rt_d;
    logic [CTRL_W-1:0] alu_ctrl_q,    alu_ctrl_d;
    logic              rsp0_valid_q,  rsp0_valid_d;
    logic [WIDTH-1:0]  rsp0_result_q, rsp0_result_d;
    logic              rsp0_zero_q,   rsp0_zero_d;
    logic              rsp1_valid_q,  rsp1_valid_d;
    logic [WIDTH-1:0]  rsp1_result_q, rsp1_result_d;
    logic              rsp1_zero_q,   rsp1_zero_d;

    logic sel0;
    logic sel1;

    // On contention the requester that was not served last wins.
    assign sel0 = req0_valid && (!req1_valid || last_grant_q);
    assign sel1 = req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = (state_q == ST_IDLE) && sel0;
    assign req1_ready = (state_q == ST_IDLE) && sel1;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        alu_rs_d      = alu_rs_q;
        alu_rt_d      = alu_rt_q;
        alu_ctrl_d    = alu_ctrl_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_zero_d   = rsp1_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (sel0) begin
                    alu_rs_d   = req0_rs;
                    alu_rt_d   = req0_rt;
                    alu_ctrl_d = req0_ctrl;
                    grant_id_d = 1'b0;
                    state_d    = ST_EXEC;
                end else if (sel1) begin
                    alu_rs_d   = req1_rs;
                    alu_rt_d   = req1_rt;
                    alu_ctrl_d = req1_ctrl;
                    grant_id_d = 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!grant_id_q) begin
                    rsp0_valid_d  = 1'b1;
                    rsp0_result_d = alu_result;
                    rsp0_zero_d   = alu_zero;
                end else begin
                    rsp1_valid_d  = 1'b1;
                    rsp1_result_d = alu_result;
                    rsp1_zero_d   = alu_zero;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!grant_id_q && rsp0_ready) begin
                    rsp0_valid_d = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (grant_id_q && rsp1_ready) begin
                    rsp1_valid_d = 1'b0;
                    last_grant_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            grant_id_q    <= 1'b0;
            alu_rs_q      <= '0;
            alu_rt_q      <= '0;
            alu_ctrl_q    <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            alu_rs_q      <= alu_rs_d;
            alu_rt_q      <= alu_rt_d;
            alu_ctrl_q    <= alu_ctrl_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

    assign alu_rs      = alu_rs_q;
    assign alu_rt      = alu_rt_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = rsp0_result_q;
    assign rsp0_zero   = rsp0_zero_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = rsp1_result_q;
    assign rsp1_zero   = rsp1_zero_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_rs, req0_rt, req1_rs, req1_rt;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp0_zero;
    logic        rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_rs, alu_rt, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;
    logic        busy;

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs(req0_rs),
        .req0_rt(req0_rt), .req0_ctrl(req0_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs(req1_rs),
        .req1_rt(req1_rt), .req1_ctrl(req1_ctrl),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; unsupported codes give 0.
    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_rs & alu_rt;
            4'b0001: alu_result = alu_rs | alu_rt;
            4'b0010: alu_result = alu_rs + alu_rt;
            4'b0110: alu_result = alu_rs - alu_rt;
            4'b0111: alu_result = {31'd0, alu_rs < alu_rt};
            4'b1100: alu_result = ~(alu_rs | alu_rt);
            default: alu_result = 32'd0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          t_acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   prev_v0 = 1'b0;
    bit   prev_v1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response monitor: latency, payload and per-requester exclusivity.
    always @(negedge clk) begin
        if (!reset) begin
            chk("excl0", {31'd0, req0_ready & rsp0_valid}, 32'd0);
            chk("excl1", {31'd0, req1_ready & rsp1_valid}, 32'd0);
            if (rsp0_valid && !prev_v0) begin
                if (q0.size() > 0) chk("lat0", cyc, q0[0].t_acc + 2);
                else               chk("unexp_rsp0", 32'd1, 32'd0);
            end
            if (rsp1_valid && !prev_v1) begin
                if (q1.size() > 0) chk("lat1", cyc, q1[0].t_acc + 2);
                else               chk("unexp_rsp1", 32'd1, 32'd0);
            end
            if (rsp0_valid && rsp0_ready && q0.size() > 0) begin
                chk("res0", rsp0_result, q0[0].res);
                chk("zero0", {31'd0, rsp0_zero}, {31'd0, q0[0].z});
                void'(q0.pop_front());
            end
            if (rsp1_valid && rsp1_ready && q1.size() > 0) begin
                chk("res1", rsp1_result, q1[0].res);
                chk("zero1", {31'd0, rsp1_zero}, {31'd0, q1[0].z});
                void'(q1.pop_front());
            end
        end
        prev_v0 = rsp0_valid;
        prev_v1 = rsp1_valid;
    end

    // Called just after a rising edge; returns just after a rising edge.
    task automatic req_op(input int id, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [3:0] ctrl, input logic [31:0] er, input logic ez,
                          output int acc, output int waited);
        exp_t e;
        bit   got = 1'b0;
        waited = 0;
        acc    = -1;
        if (id == 0) begin
            req0_valid = 1'b1; req0_rs = rs; req0_rt = rt; req0_ctrl = ctrl;
        end else begin
            req1_valid = 1'b1; req1_rs = rs; req1_rt = rt; req1_ctrl = ctrl;
        end
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) begin
                got     = 1'b1;
                acc     = cyc;
                e.res   = er;
                e.z     = ez;
                e.t_acc = cyc;
                if (id == 0) q0.push_back(e);
                else         q1.push_back(e);
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
        if (!got) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy) done = 1'b1;
        end
        @(posedge clk); #1;
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, w0, w1, acc, w;
        reset = 1'b1;
        req0_valid = 1'b0; req0_rs = '0; req0_rt = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_rs = '0; req1_rt = '0; req1_ctrl = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_alu_rs", alu_rs, 32'd0);
        chk("rst_alu_rt", alu_rt, 32'd0);
        chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_rsp_result", rsp0_result | rsp1_result, 32'd0);
        chk("rst_rsp_zero", {30'd0, rsp1_zero, rsp0_zero}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Simultaneous requests straight out of reset: req0 wins first.
        fork
            req_op(0, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, a0, w0);
            req_op(1, 32'h0F0, 32'h00F, 4'b0001, 32'h0FF, 1'b0, a1, w1);
        join
        chk("rr_first_req0", {31'd0, a0 < a1}, 32'd1);
        drain();
        fork
            req_op(0, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, a0, w0);
            req_op(1, 32'h0F0, 32'h00F, 4'b0001, 32'h0FF, 1'b0, a1, w1);
        join
        chk("rr_repeat_req0", {31'd0, a0 < a1}, 32'd1);
        chk("rr_wait_req0", w0, 32'd0);
        drain();

        // Single add on requester 0.
        req_op(0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, acc, w);
        chk("single_wait", w, 32'd0);
        drain();

        // Backpressure on requester 1 with req0 pending.
        rsp1_ready = 1'b0;
        req_op(1, 32'hFFFF0000, 32'h12345678, 4'b0000, 32'h12340000, 1'b0, acc, w);
        req0_valid = 1'b1; req0_rs = 32'd1; req0_rt = 32'd2; req0_ctrl = 4'b0010;
        @(negedge clk);
        chk("bp_exec_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp1_valid}, 32'd1);
            chk("bp_result", rsp1_result, 32'h12340000);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        chk("bp_req0_ready_hs", {31'd0, req0_ready}, 32'd0);
        @(posedge clk); #1;
        req_op(0, 32'd1, 32'd2, 4'b0010, 32'd3, 1'b0, acc, w);
        chk("bp_req0_after", w, 32'd0);
        drain();

        // Unsigned set-less-than, both orders.
        req_op(0, 32'hFFFFFFFF, 32'd1, 4'b0111, 32'd0, 1'b1, acc, w);
        drain();
        req_op(0, 32'd1, 32'hFFFFFFFF, 4'b0111, 32'd1, 1'b0, acc, w);
        drain();

        // Unsupported control code passes through.
        req_op(1, 32'd3, 32'd4, 4'b1111, 32'd0, 1'b1, acc, w);
        drain();

        // Reset during EXEC discards the operation.
        req_op(0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, acc, w);
        reset = 1'b1;
        q0.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("mid_rst_alu_rs", alu_rs, 32'd0);
        chk("mid_rst_alu_rt", alu_rt, 32'd0);
        chk("mid_rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_op(0, 32'd10, 32'd3, 4'b0110, 32'd7, 1'b0, acc, w);
        chk("post_rst_accept", w, 32'd0);
        drain();

        chk("queues_empty", q0.size() + q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
